// File: rtl/uproc_sequencer_if.sv
// -----------------------------------------------------------------------------
// uproc_sequencer_if
// Bundle between the multi-cycle control sequencer and the 8-bit datapath.
//
// Signals
//   run        datapath/host -> sequencer  level, 1 = sequencer may leave FETCH
//   instr_in   datapath -> sequencer       instruction word at current PC
//   ir_out     sequencer -> datapath       latched instruction register
//   c_ALU      sequencer -> datapath       ALU operation select
//   c_Inm      sequencer -> datapath       1 = ALU B from immediate
//   c_extend   sequencer -> datapath       1 = sign-extend 4-bit immediate
//   reg_we     sequencer -> datapath       register-file write enable
//   pc_en      sequencer -> datapath       PC increment (one-cycle pulse)
//   halted     sequencer -> observer       high while halted
//   illegal    sequencer -> observer       pulse on undefined opcode
//   retired    sequencer -> observer       completed-instruction count
//   state_out  sequencer -> observer       FSM state, debug
//
// Modports: master = sequencer side, slave = datapath/observer side.
// -----------------------------------------------------------------------------
interface uproc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [15:0]      instr_in;
    logic [15:0]      ir_out;
    logic [1:0]       c_ALU;
    logic             c_Inm;
    logic             c_extend;
    logic             reg_we;
    logic             pc_en;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_out;

    modport master (
        input  run, instr_in,
        output ir_out, c_ALU, c_Inm, c_extend, reg_we, pc_en,
               halted, illegal, retired, state_out
    );

    modport slave (
        output run, instr_in,
        input  ir_out, c_ALU, c_Inm, c_extend, reg_we, pc_en,
               halted, illegal, retired, state_out
    );
endinterface

// File: rtl/uproc_sequencer.sv
// -----------------------------------------------------------------------------
// uproc_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM for the 8-bit
// immediate-capable datapath. Latches each instruction, decodes the opcode
// (instr[15:12]) and sequences ALU/immediate controls, register write and PC
// advance. Adds a HALT state (left only by reset) and a retired counter.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, priority over everything
//   step   (only with SEQ_SINGLE_STEP_EN) single-step pulse input
//   bus    uproc_sequencer_if.master, see interface header
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   Defined  : FETCH is left only on run=1 plus a rising edge of step.
//   Undefined: FETCH is left whenever run=1.
//
// All outputs are registered. Output registers are loaded on the same edge
// that enters the state they belong to, so e.g. illegal is high during the
// DECODE cycle and reg_we/pc_en are high during the WRITEBACK cycle.
// -----------------------------------------------------------------------------
module uproc_sequencer #(
    parameter int CNT_W = 16,
    parameter int OP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    uproc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ILL0 = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ILL1 = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);
    localparam logic [OP_W-1:0] OP_LAST_WRITE = OP_W'(11);

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [1:0]       alu_q, alu_d;
    logic             inm_q, inm_d;
    logic             ext_q, ext_d;
    logic             we_q, we_d;
    logic             pc_en_q, pc_en_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [OP_W-1:0]  op_in;   // opcode of the word being fetched
    logic [OP_W-1:0]  op_ir;   // opcode of the latched instruction
    logic             go;      // permission to leave FETCH this cycle

    assign op_in = bus.instr_in[15 -: OP_W];
    assign op_ir = ir_q[15 -: OP_W];

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    // Edge detector runs in every state; only FETCH looks at the result,
    // which is how pulses arriving mid-instruction get dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign go = bus.run & step & ~step_q;
`else
    assign go = bus.run;
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_d     = alu_q;
        inm_d     = inm_q;
        ext_d     = ext_q;
        we_d      = 1'b0;
        pc_en_d   = 1'b0;
        halted_d  = halted_q;
        illegal_d = 1'b0;
        retired_d = retired_q;

        case (state_q)
            S_FETCH: begin
                if (go) begin
                    ir_d    = bus.instr_in;
                    state_d = S_DECODE;
                    // Controls are decoded from the incoming word so they are
                    // already valid while the FSM sits in DECODE.
                    if (op_in <= OP_LAST_WRITE) begin
                        alu_d = op_in[1:0];
                        inm_d = op_in[3] | op_in[2];
                        ext_d = op_in[3];
                    end else if (op_in == OP_NOP) begin
                        alu_d = 2'd0;
                        inm_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (op_in == OP_ILL0 || op_in == OP_ILL1) begin
                        alu_d     = 2'd0;
                        inm_d     = 1'b0;
                        ext_d     = 1'b0;
                        illegal_d = 1'b1;
                    end
                    // HALT keeps whatever controls were last driven.
                end
            end
            S_DECODE: begin
                if (op_ir == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d   = S_WRITEBACK;
                we_d      = (op_ir <= OP_LAST_WRITE);
                pc_en_d   = 1'b1;
                retired_d = retired_q + CNT_W'(1);
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= 16'd0;
            alu_q     <= 2'd0;
            inm_q     <= 1'b0;
            ext_q     <= 1'b0;
            we_q      <= 1'b0;
            pc_en_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            inm_q     <= inm_d;
            ext_q     <= ext_d;
            we_q      <= we_d;
            pc_en_q   <= pc_en_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.ir_out    = ir_q;
    assign bus.c_ALU     = alu_q;
    assign bus.c_Inm     = inm_q;
    assign bus.c_extend  = ext_q;
    assign bus.reg_we    = we_q;
    assign bus.pc_en     = pc_en_q;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;
    assign bus.retired   = retired_q;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_uproc_sequencer.sv
module tb_uproc_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uproc_sequencer_if #(.CNT_W(16)) bus ();

    uproc_sequencer #(.CNT_W(16), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Present a word with run=1 for one edge, leaving the FSM in DECODE.
    task automatic start(input logic [15:0] w);
        bus.run = 1'b1;
        bus.instr_in = w;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        tick();
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        bus.run = 1'b0;
    endtask

    // Run one complete instruction, counting output pulses along the way.
    task automatic run_instr(input logic [15:0] w, output int we_c, output int pc_c,
                             output int ill_c, output logic ill_dec);
        we_c = 0; pc_c = 0; ill_c = 0;
        start(w);
        ill_dec = bus.illegal;
        ill_c += int'(bus.illegal);
        for (int i = 0; i < 8; i++) begin
            tick();
            we_c  += int'(bus.reg_we);
            pc_c  += int'(bus.pc_en);
            ill_c += int'(bus.illegal);
            if (bus.state_out == 3'd0) break;
        end
    endtask

    task automatic test_reset();
        bus.instr_in = 16'hABCD;
        do_reset();
        n_cmp++; if (bus.state_out !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state_out); end
        n_cmp++; if (bus.ir_out !== 16'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", bus.ir_out); end
        n_cmp++; if ({bus.c_ALU, bus.c_Inm, bus.c_extend, bus.reg_we, bus.pc_en, bus.halted, bus.illegal} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000000",
                {bus.c_ALU, bus.c_Inm, bus.c_extend, bus.reg_we, bus.pc_en, bus.halted, bus.illegal});
        end
        n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        $display("test_reset: state=%0d ir=%h retired=%0d", bus.state_out, bus.ir_out, bus.retired);
    endtask

    task automatic test_reg_op();
        start(16'h0123);
        n_cmp++; if (bus.state_out !== 3'd1) begin n_fail++; $display("FAIL regop_decode_state: got %0d want 1", bus.state_out); end
        n_cmp++; if (bus.ir_out !== 16'h0123) begin n_fail++; $display("FAIL regop_ir: got %h want 0123", bus.ir_out); end
        n_cmp++; if ({bus.c_ALU, bus.c_Inm} !== 3'b000) begin n_fail++; $display("FAIL regop_ctrl: got %b want 000", {bus.c_ALU, bus.c_Inm}); end
        tick(); // EXECUTE
        n_cmp++; if ({bus.state_out, bus.reg_we, bus.pc_en} !== {3'd2, 2'b00}) begin
            n_fail++; $display("FAIL regop_exec: got st=%0d we=%b pc=%b want st=2 we=0 pc=0", bus.state_out, bus.reg_we, bus.pc_en); end
        tick(); // WRITEBACK
        n_cmp++; if ({bus.state_out, bus.reg_we, bus.pc_en} !== {3'd3, 2'b11}) begin
            n_fail++; $display("FAIL regop_wb: got st=%0d we=%b pc=%b want st=3 we=1 pc=1", bus.state_out, bus.reg_we, bus.pc_en); end
        n_cmp++; if (bus.retired !== 16'd1) begin n_fail++; $display("FAIL regop_retired: got %0d want 1", bus.retired); end
        tick(); // back in FETCH
        n_cmp++; if ({bus.state_out, bus.reg_we, bus.pc_en} !== {3'd0, 2'b00}) begin
            n_fail++; $display("FAIL regop_fetch: got st=%0d we=%b pc=%b want st=0 we=0 pc=0", bus.state_out, bus.reg_we, bus.pc_en); end
        $display("test_reg_op: instr=0123 retired=%0d", bus.retired);
    endtask

    task automatic test_imm();
        start(16'h9A50);
        n_cmp++; if ({bus.c_ALU, bus.c_Inm, bus.c_extend} !== 4'b0111) begin
            n_fail++; $display("FAIL imm_sign_ctrl: got %b want 0111", {bus.c_ALU, bus.c_Inm, bus.c_extend}); end
        tick(); tick();
        n_cmp++; if (bus.reg_we !== 1'b1) begin n_fail++; $display("FAIL imm_sign_we: got %b want 1", bus.reg_we); end
        n_cmp++; if ({bus.c_ALU, bus.c_Inm, bus.c_extend} !== 4'b0111) begin
            n_fail++; $display("FAIL imm_sign_hold: got %b want 0111", {bus.c_ALU, bus.c_Inm, bus.c_extend}); end
        tick();
        start(16'h6000);
        n_cmp++; if ({bus.c_ALU, bus.c_Inm, bus.c_extend} !== 4'b1010) begin
            n_fail++; $display("FAIL imm_zero_ctrl: got %b want 1010", {bus.c_ALU, bus.c_Inm, bus.c_extend}); end
        tick(); tick(); tick();
        $display("test_imm: 9A50 and 6000 done retired=%0d", bus.retired);
    endtask

    task automatic test_stream();
        int we_t, pc_t, ill_t, a, b, c;
        logic d, ill_d000;
        do_reset();
        we_t = 0; pc_t = 0; ill_t = 0;
        run_instr(16'h4000, a, b, c, d); we_t += a; pc_t += b; ill_t += c;
        run_instr(16'hC000, a, b, c, d); we_t += a; pc_t += b; ill_t += c;
        run_instr(16'hD000, a, b, c, ill_d000); we_t += a; pc_t += b; ill_t += c;
        n_cmp++; if (we_t !== 1) begin n_fail++; $display("FAIL stream_we: got %0d want 1", we_t); end
        n_cmp++; if (pc_t !== 3) begin n_fail++; $display("FAIL stream_pc: got %0d want 3", pc_t); end
        n_cmp++; if (ill_t !== 1) begin n_fail++; $display("FAIL stream_ill_count: got %0d want 1", ill_t); end
        n_cmp++; if (ill_d000 !== 1'b1) begin n_fail++; $display("FAIL stream_ill_decode: got %b want 1", ill_d000); end
        n_cmp++; if (bus.retired !== 16'd3) begin n_fail++; $display("FAIL stream_retired: got %0d want 3", bus.retired); end
        $display("test_stream: we=%0d pc=%0d ill=%0d retired=%0d", we_t, pc_t, ill_t, bus.retired);
    endtask

    task automatic test_halt();
        int a, b, c, bad;
        logic d;
        do_reset();
        run_instr(16'h1000, a, b, c, d);
        start(16'hF000);
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_decode: got %b want 0", bus.halted); end
        bus.run = 1'b1;
        tick();
        n_cmp++; if ({bus.state_out, bus.halted} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL halt_enter: got st=%0d h=%b want st=4 h=1", bus.state_out, bus.halted); end
        a = 0; bad = 0;
        for (int i = 0; i < 22; i++) begin
            bus.run = i[0];
            tick();
            a += int'(bus.reg_we) + int'(bus.pc_en);
            if (bus.state_out != 3'd4 || bus.halted != 1'b1) bad++;
        end
        n_cmp++; if (a !== 0) begin n_fail++; $display("FAIL halt_pulses: got %0d want 0", a); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL halt_stuck: got %0d bad cycles want 0", bad); end
        n_cmp++; if (bus.retired !== 16'd1) begin n_fail++; $display("FAIL halt_retired: got %0d want 1", bus.retired); end
        do_reset();
        n_cmp++; if ({bus.state_out, bus.halted} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL halt_reset: got st=%0d h=%b want st=0 h=0", bus.state_out, bus.halted); end
        $display("test_halt: halted held 22 cycles, reset state=%0d", bus.state_out);
    endtask

    task automatic test_reset_mid();
        int we_c;
        do_reset();
        start(16'h1234);
        tick();
        n_cmp++; if (bus.state_out !== 3'd2) begin n_fail++; $display("FAIL mid_exec: got %0d want 2", bus.state_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", bus.state_out); end
        we_c = int'(bus.reg_we);
        for (int i = 0; i < 5; i++) begin tick(); we_c += int'(bus.reg_we); end
        n_cmp++; if (we_c !== 0) begin n_fail++; $display("FAIL mid_we: got %0d want 0", we_c); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL mid_retired: got %0d want 0", bus.retired); end
        $display("test_reset_mid: state=%0d retired=%0d", bus.state_out, bus.retired);
    endtask

    task automatic test_run_low();
        int a, b, c, moved;
        logic d;
        run_instr(16'h5A5A, a, b, c, d);
        bus.run = 1'b0;
        bus.instr_in = 16'hFFFF;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.state_out != 3'd0) moved++;
        end
        n_cmp++; if (moved !== 0) begin n_fail++; $display("FAIL runlow_state: got %0d non-FETCH cycles want 0", moved); end
        n_cmp++; if (bus.ir_out !== 16'h5A5A) begin n_fail++; $display("FAIL runlow_ir: got %h want 5a5a", bus.ir_out); end
        $display("test_run_low: ir=%h held 10 cycles", bus.ir_out);
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        int pc_c, moved;
        do_reset();
        bus.run = 1'b1;
        bus.instr_in = 16'h2000;
        step = 1'b0;
        moved = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.state_out != 3'd0) moved++;
        end
        n_cmp++; if (moved !== 0) begin n_fail++; $display("FAIL step_wait: got %0d non-FETCH cycles want 0", moved); end
        // Pulses at 0 and 8 start instructions; the pulse at 2 lands mid-instruction.
        pc_c = 0;
        for (int i = 0; i < 20; i++) begin
            step = (i == 0 || i == 2 || i == 8);
            tick();
            pc_c += int'(bus.pc_en);
        end
        step = 1'b0;
        bus.run = 1'b0;
        n_cmp++; if (pc_c !== 2) begin n_fail++; $display("FAIL step_pc: got %0d want 2", pc_c); end
        n_cmp++; if (bus.retired !== 16'd2) begin n_fail++; $display("FAIL step_retired: got %0d want 2", bus.retired); end
        $display("test_single_step: pc pulses=%0d retired=%0d", pc_c, bus.retired);
    endtask
`endif

    initial begin
        bus.run = 1'b0;
        bus.instr_in = 16'h0000;
        test_reset();
        test_reg_op();
        test_imm();
        test_stream();
        test_halt();
        test_reset_mid();
        test_run_low();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
